// File: rtl/mesi_pkg.sv
// Shared types for the MESI cache controller: line states, bus commands and FSM states.
package mesi_pkg;

   typedef enum logic [1:0] {
      LsI = 2'd0,
      LsS = 2'd1,
      LsM = 2'd2,
      LsE = 2'd3
   } line_state_e;

   typedef enum logic [1:0] {
      CmdNone    = 2'd0,
      CmdBusRd   = 2'd1,
      CmdBusRdX  = 2'd2,
      CmdBusUpgr = 2'd3
   } bus_cmd_e;

   typedef enum logic [2:0] {
      StIdle,
      StUpgr,
      StWb,
      StMiss,
      StFill,
      StDone
   } fsm_state_e;

endpackage

// File: rtl/mesi_line_array.sv
// Direct-mapped tag/state/data storage with a CPU-side and a snoop-side read port.
// A same-cycle snoop state write is forwarded to the CPU port so own updates build on it.
module mesi_line_array
   import mesi_pkg::*;
#(
   parameter int unsigned IDX_W  = 2,
   parameter int unsigned TAG_W  = 3,
   parameter int unsigned DATA_W = 8
) (
   input  logic              i_clock,
   input  logic              i_reset_n,
   input  logic [IDX_W-1:0]  i_cpu_idx,
   output logic [TAG_W-1:0]  o_cpu_tag,
   output line_state_e       o_cpu_state,
   output logic [DATA_W-1:0] o_cpu_data,
   input  logic [IDX_W-1:0]  i_snp_idx,
   output logic [TAG_W-1:0]  o_snp_tag,
   output line_state_e       o_snp_state,
   output logic [DATA_W-1:0] o_snp_data,
   input  logic              i_snp_we,
   input  line_state_e       i_snp_state,
   input  logic              i_cpu_we,
   input  logic [TAG_W-1:0]  i_cpu_wtag,
   input  line_state_e       i_cpu_wstate,
   input  logic [DATA_W-1:0] i_cpu_wdata
);

   localparam int unsigned LINES = 2 ** IDX_W;

   line_state_e       r_state [LINES];
   logic [TAG_W-1:0]  r_tag   [LINES];
   logic [DATA_W-1:0] r_data  [LINES];

   assign o_cpu_tag   = r_tag[i_cpu_idx];
   assign o_cpu_data  = r_data[i_cpu_idx];
   assign o_cpu_state = (i_snp_we && (i_snp_idx == i_cpu_idx)) ? i_snp_state
                                                                 : r_state[i_cpu_idx];

   assign o_snp_tag   = r_tag[i_snp_idx];
   assign o_snp_state = r_state[i_snp_idx];
   assign o_snp_data  = r_data[i_snp_idx];

   // CPU write is issued last so it overrides the snoop on a shared index.
   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         for (int i = 0; i < LINES; i++) r_state[i] <= LsI;
      end else begin
         if (i_snp_we) r_state[i_snp_idx] <= i_snp_state;
         if (i_cpu_we) r_state[i_cpu_idx] <= i_cpu_wstate;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset_n && i_cpu_we) begin
         r_tag[i_cpu_idx]  <= i_cpu_wtag;
         r_data[i_cpu_idx] <= i_cpu_wdata;
      end
   end

endmodule

// File: rtl/mesi_cache_ctrl.sv
// Direct-mapped MESI cache controller: CPU request FSM, bus requester and snoop responder.
module mesi_cache_ctrl
   import mesi_pkg::*;
#(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned LINES  = 4
) (
   input  logic              i_clock,
   input  logic              i_reset_n,
   input  logic              i_cpu_req,
   input  logic              i_cpu_we,
   input  logic [ADDR_W-1:0] i_cpu_addr,
   input  logic [DATA_W-1:0] i_cpu_wdata,
   output logic              o_cpu_ready,
   output logic [DATA_W-1:0] o_cpu_rdata,
   output logic              o_bus_req,
   input  logic              i_bus_gnt,
   output logic [1:0]        o_bus_cmd,
   output logic              o_bus_wb,
   output logic [ADDR_W-1:0] o_bus_addr,
   output logic [DATA_W-1:0] o_bus_wdata,
   input  logic              i_mem_valid,
   input  logic [DATA_W-1:0] i_mem_rdata,
   input  logic              i_bus_shared_in,
   input  logic              i_snp_valid,
   input  logic [1:0]        i_snp_cmd,
   input  logic [ADDR_W-1:0] i_snp_addr,
   output logic              o_snp_shared,
   output logic              o_snp_flush,
   output logic [DATA_W-1:0] o_snp_data
);

   localparam int unsigned IDX_W = $clog2(LINES);
   localparam int unsigned TAG_W = ADDR_W - IDX_W;

   fsm_state_e        r_state, w_state_n;
   logic [ADDR_W-1:0] r_addr;
   logic              r_we;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata, w_rdata_n;
   logic              r_snp_shared, r_snp_flush;
   logic [DATA_W-1:0] r_snp_data;

   logic [ADDR_W-1:0] w_addr;
   logic [IDX_W-1:0]  w_idx;
   logic [TAG_W-1:0]  w_tag;
   logic [TAG_W-1:0]  w_line_tag;
   line_state_e       w_line_state;
   logic [DATA_W-1:0] w_line_data;
   logic              w_cpu_hit;
   logic              w_accept;

   logic              w_wr_en;
   logic [TAG_W-1:0]  w_wr_tag;
   line_state_e       w_wr_state;
   logic [DATA_W-1:0] w_wr_data;

   logic [IDX_W-1:0]  w_snp_idx;
   logic [TAG_W-1:0]  w_snp_tag;
   logic [TAG_W-1:0]  w_snp_line_tag;
   line_state_e       w_snp_line_state;
   logic [DATA_W-1:0] w_snp_line_data;
   bus_cmd_e          w_snp_cmd;
   logic              w_snp_hit;
   logic              w_snp_we;
   line_state_e       w_snp_new;
   logic              w_snp_shared, w_snp_flush;
   logic [DATA_W-1:0] w_snp_data;

   // The request address is only captured on acceptance; until then look up the live input.
   assign w_addr    = (r_state == StIdle) ? i_cpu_addr : r_addr;
   assign w_idx     = w_addr[ADDR_W-1 -: IDX_W];
   assign w_tag     = w_addr[TAG_W-1:0];
   assign w_cpu_hit = (w_line_tag == w_tag) && (w_line_state != LsI);

   assign w_snp_idx = i_snp_addr[ADDR_W-1 -: IDX_W];
   assign w_snp_tag = i_snp_addr[TAG_W-1:0];
   assign w_snp_cmd = bus_cmd_e'(i_snp_cmd);
   assign w_snp_hit = i_snp_valid && (w_snp_line_tag == w_snp_tag) && (w_snp_line_state != LsI);

   mesi_line_array #(
      .IDX_W  (IDX_W),
      .TAG_W  (TAG_W),
      .DATA_W (DATA_W)
   ) u_lines (
      .i_clock      (i_clock),
      .i_reset_n    (i_reset_n),
      .i_cpu_idx    (w_idx),
      .o_cpu_tag    (w_line_tag),
      .o_cpu_state  (w_line_state),
      .o_cpu_data   (w_line_data),
      .i_snp_idx    (w_snp_idx),
      .o_snp_tag    (w_snp_line_tag),
      .o_snp_state  (w_snp_line_state),
      .o_snp_data   (w_snp_line_data),
      .i_snp_we     (w_snp_we),
      .i_snp_state  (w_snp_new),
      .i_cpu_we     (w_wr_en),
      .i_cpu_wtag   (w_wr_tag),
      .i_cpu_wstate (w_wr_state),
      .i_cpu_wdata  (w_wr_data)
   );

   always_comb begin
      w_snp_we     = 1'b0;
      w_snp_new    = w_snp_line_state;
      w_snp_shared = 1'b0;
      w_snp_flush  = 1'b0;
      if (w_snp_hit) begin
         unique case (w_snp_cmd)
            CmdBusRd: begin
               w_snp_we     = 1'b1;
               w_snp_new    = LsS;
               w_snp_shared = 1'b1;
               w_snp_flush  = (w_snp_line_state == LsM);
            end
            CmdBusRdX, CmdBusUpgr: begin
               w_snp_we    = 1'b1;
               w_snp_new   = LsI;
               w_snp_flush = (w_snp_line_state == LsM);
            end
            default: ;
         endcase
      end
      w_snp_data = w_snp_flush ? w_snp_line_data : '0;
   end

   always_comb begin
      w_state_n   = r_state;
      w_rdata_n   = r_rdata;
      w_accept    = 1'b0;
      w_wr_en     = 1'b0;
      w_wr_tag    = w_line_tag;
      w_wr_state  = w_line_state;
      w_wr_data   = w_line_data;
      o_bus_req   = 1'b0;
      o_bus_cmd   = CmdNone;
      o_bus_wb    = 1'b0;
      o_bus_addr  = '0;
      o_bus_wdata = '0;
      o_cpu_ready = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (i_cpu_req) begin
               w_accept = 1'b1;
               if (w_cpu_hit) begin
                  if (!i_cpu_we) begin
                     w_rdata_n = w_line_data;
                     w_state_n = StDone;
                  end else if (w_line_state == LsS) begin
                     w_state_n = StUpgr;
                  end else begin
                     w_wr_en    = 1'b1;
                     w_wr_state = LsM;
                     w_wr_data  = i_cpu_wdata;
                     w_state_n  = StDone;
                  end
               end else if (w_line_state == LsM) begin
                  w_state_n = StWb;
               end else begin
                  w_state_n = StMiss;
               end
            end
         end
         StUpgr: begin
            o_bus_req  = 1'b1;
            o_bus_cmd  = CmdBusUpgr;
            o_bus_addr = r_addr;
            // Losing the line to a snoop turns the upgrade into a full read-exclusive.
            if (!w_cpu_hit) begin
               w_state_n = StMiss;
            end else if (i_bus_gnt) begin
               w_wr_en    = 1'b1;
               w_wr_state = LsM;
               w_wr_data  = r_wdata;
               w_state_n  = StDone;
            end
         end
         StWb: begin
            o_bus_req   = 1'b1;
            o_bus_wb    = 1'b1;
            o_bus_addr  = {w_idx, w_line_tag};
            o_bus_wdata = w_line_data;
            if (w_line_state != LsM) begin
               w_state_n = StMiss;
            end else if (i_bus_gnt) begin
               w_wr_en    = 1'b1;
               w_wr_state = LsI;
               w_state_n  = StMiss;
            end
         end
         StMiss: begin
            o_bus_req  = 1'b1;
            o_bus_cmd  = r_we ? CmdBusRdX : CmdBusRd;
            o_bus_addr = r_addr;
            if (i_bus_gnt) w_state_n = StFill;
         end
         StFill: begin
            if (i_mem_valid) begin
               w_wr_en  = 1'b1;
               w_wr_tag = w_tag;
               if (r_we) begin
                  w_wr_state = LsM;
                  w_wr_data  = r_wdata;
               end else begin
                  w_wr_state = i_bus_shared_in ? LsS : LsE;
                  w_wr_data  = i_mem_rdata;
                  w_rdata_n  = i_mem_rdata;
               end
               w_state_n = StDone;
            end
         end
         StDone: begin
            o_cpu_ready = 1'b1;
            w_state_n   = StIdle;
         end
         default: w_state_n = StIdle;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_state      <= StIdle;
         r_addr       <= '0;
         r_we         <= 1'b0;
         r_wdata      <= '0;
         r_rdata      <= '0;
         r_snp_shared <= 1'b0;
         r_snp_flush  <= 1'b0;
         r_snp_data   <= '0;
      end else begin
         r_state      <= w_state_n;
         r_rdata      <= w_rdata_n;
         r_snp_shared <= w_snp_shared;
         r_snp_flush  <= w_snp_flush;
         r_snp_data   <= w_snp_data;
         if (w_accept) begin
            r_addr  <= i_cpu_addr;
            r_we    <= i_cpu_we;
            r_wdata <= i_cpu_wdata;
         end
      end
   end

   assign o_cpu_rdata  = r_rdata;
   assign o_snp_shared = r_snp_shared;
   assign o_snp_flush  = r_snp_flush;
   assign o_snp_data   = r_snp_data;

endmodule

// File: tb/tb_mesi_cache_ctrl.sv
// Directed scenario bench for mesi_cache_ctrl; inputs change and outputs are sampled 1ns after
// each rising edge.
module tb_mesi_cache_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       cpu_req, cpu_we;
   logic [4:0] cpu_addr;
   logic [7:0] cpu_wdata;
   logic       cpu_ready;
   logic [7:0] cpu_rdata;
   logic       bus_req, bus_gnt;
   logic [1:0] bus_cmd;
   logic       bus_wb;
   logic [4:0] bus_addr;
   logic [7:0] bus_wdata;
   logic       mem_valid;
   logic [7:0] mem_rdata;
   logic       bus_shared_in;
   logic       snp_valid;
   logic [1:0] snp_cmd;
   logic [4:0] snp_addr;
   logic       snp_shared, snp_flush;
   logic [7:0] snp_data;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   mesi_cache_ctrl #(
      .ADDR_W (5),
      .DATA_W (8),
      .LINES  (4)
   ) dut (
      .i_clock         (clk),
      .i_reset_n       (reset_n),
      .i_cpu_req       (cpu_req),
      .i_cpu_we        (cpu_we),
      .i_cpu_addr      (cpu_addr),
      .i_cpu_wdata     (cpu_wdata),
      .o_cpu_ready     (cpu_ready),
      .o_cpu_rdata     (cpu_rdata),
      .o_bus_req       (bus_req),
      .i_bus_gnt       (bus_gnt),
      .o_bus_cmd       (bus_cmd),
      .o_bus_wb        (bus_wb),
      .o_bus_addr      (bus_addr),
      .o_bus_wdata     (bus_wdata),
      .i_mem_valid     (mem_valid),
      .i_mem_rdata     (mem_rdata),
      .i_bus_shared_in (bus_shared_in),
      .i_snp_valid     (snp_valid),
      .i_snp_cmd       (snp_cmd),
      .i_snp_addr      (snp_addr),
      .o_snp_shared    (snp_shared),
      .o_snp_flush     (snp_flush),
      .o_snp_data      (snp_data)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      bus_gnt = 0; mem_valid = 0; mem_rdata = '0; bus_shared_in = 0;
      snp_valid = 0; snp_cmd = '0; snp_addr = '0;
      tick(); tick();
      n_total++; if (bus_req !== 1'b0) $display("FAIL rst_bus_req got=%0h exp=0", bus_req); else n_pass++;
      n_total++; if (cpu_ready !== 1'b0) $display("FAIL rst_ready got=%0h exp=0", cpu_ready); else n_pass++;
      n_total++; if (cpu_rdata !== 8'h00) $display("FAIL rst_rdata got=%0h exp=0", cpu_rdata); else n_pass++;
      n_total++; if ({bus_cmd, bus_wb, bus_addr, bus_wdata} !== 16'h0)
         $display("FAIL rst_bus_outs got=%0h exp=0", {bus_cmd, bus_wb, bus_addr, bus_wdata}); else n_pass++;
      n_total++; if ({snp_shared, snp_flush, snp_data} !== 10'h0)
         $display("FAIL rst_snp_outs got=%0h exp=0", {snp_shared, snp_flush, snp_data}); else n_pass++;
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_read_miss();
      cpu_req = 1; cpu_we = 0; cpu_addr = 5'h0A;
      tick();
      n_total++; if (bus_req !== 1'b1) $display("FAIL rdmiss_req got=%0h exp=1", bus_req); else n_pass++;
      n_total++; if (bus_cmd !== 2'd1) $display("FAIL rdmiss_cmd got=%0h exp=1", bus_cmd); else n_pass++;
      n_total++; if (bus_addr !== 5'h0A) $display("FAIL rdmiss_addr got=%0h exp=0a", bus_addr); else n_pass++;
      bus_gnt = 1; tick(); bus_gnt = 0;
      n_total++; if (bus_req !== 1'b0) $display("FAIL rdmiss_fill_req got=%0h exp=0", bus_req); else n_pass++;
      mem_valid = 1; mem_rdata = 8'h5C; bus_shared_in = 0;
      tick(); mem_valid = 0;
      n_total++; if (cpu_ready !== 1'b1) $display("FAIL rdmiss_ready got=%0h exp=1", cpu_ready); else n_pass++;
      n_total++; if (cpu_rdata !== 8'h5C) $display("FAIL rdmiss_rdata got=%0h exp=5c", cpu_rdata); else n_pass++;
      cpu_req = 0; tick();
      n_total++; if (cpu_ready !== 1'b0) $display("FAIL rdmiss_pulse got=%0h exp=0", cpu_ready); else n_pass++;
      cpu_req = 1; tick();
      n_total++; if (cpu_ready !== 1'b1) $display("FAIL rdhit_ready got=%0h exp=1", cpu_ready); else n_pass++;
      n_total++; if (cpu_rdata !== 8'h5C) $display("FAIL rdhit_rdata got=%0h exp=5c", cpu_rdata); else n_pass++;
      n_total++; if (bus_req !== 1'b0) $display("FAIL rdhit_noreq got=%0h exp=0", bus_req); else n_pass++;
      cpu_req = 0; tick();
   endtask

   task automatic test_write_hit_e();
      cpu_req = 1; cpu_we = 1; cpu_addr = 5'h0A; cpu_wdata = 8'h33;
      tick();
      n_total++; if (cpu_ready !== 1'b1) $display("FAIL wre_ready got=%0h exp=1", cpu_ready); else n_pass++;
      n_total++; if (bus_req !== 1'b0) $display("FAIL wre_noreq got=%0h exp=0", bus_req); else n_pass++;
      cpu_req = 0; cpu_we = 0; tick();
      snp_valid = 1; snp_cmd = 2'd1; snp_addr = 5'h0A;
      tick(); snp_valid = 0;
      n_total++; if (snp_flush !== 1'b1) $display("FAIL snprd_m_flush got=%0h exp=1", snp_flush); else n_pass++;
      n_total++; if (snp_data !== 8'h33) $display("FAIL snprd_m_data got=%0h exp=33", snp_data); else n_pass++;
      n_total++; if (snp_shared !== 1'b1) $display("FAIL snprd_m_shared got=%0h exp=1", snp_shared); else n_pass++;
      tick();
      n_total++; if ({snp_shared, snp_flush, snp_data} !== 10'h0)
         $display("FAIL snp_one_cycle got=%0h exp=0", {snp_shared, snp_flush, snp_data}); else n_pass++;
   endtask

   task automatic test_upgrade();
      cpu_req = 1; cpu_we = 1; cpu_addr = 5'h0A; cpu_wdata = 8'h44;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_total++; if (bus_req !== 1'b1 || bus_cmd !== 2'd3 || bus_addr !== 5'h0A)
            $display("FAIL upgr_hold%0d got=%0h/%0h/%0h exp=1/3/0a", i, bus_req, bus_cmd, bus_addr);
         else n_pass++;
      end
      bus_gnt = 1; tick(); bus_gnt = 0;
      n_total++; if (cpu_ready !== 1'b1) $display("FAIL upgr_ready got=%0h exp=1", cpu_ready); else n_pass++;
      n_total++; if (bus_req !== 1'b0) $display("FAIL upgr_req_drop got=%0h exp=0", bus_req); else n_pass++;
      cpu_req = 0; cpu_we = 0; tick();
   endtask

   task automatic test_writeback();
      cpu_req = 1; cpu_we = 0; cpu_addr = 5'h0D;
      tick();
      n_total++; if (bus_req !== 1'b1 || bus_wb !== 1'b1)
         $display("FAIL wb_req got=%0h/%0h exp=1/1", bus_req, bus_wb); else n_pass++;
      n_total++; if (bus_addr !== 5'h0A) $display("FAIL wb_addr got=%0h exp=0a", bus_addr); else n_pass++;
      n_total++; if (bus_wdata !== 8'h44) $display("FAIL wb_data got=%0h exp=44", bus_wdata); else n_pass++;
      bus_gnt = 1; tick(); bus_gnt = 0;
      n_total++; if (bus_req !== 1'b1 || bus_wb !== 1'b0 || bus_cmd !== 2'd1 || bus_addr !== 5'h0D)
         $display("FAIL wb_then_rd got=%0h/%0h/%0h/%0h exp=1/0/1/0d", bus_req, bus_wb, bus_cmd,
                  bus_addr);
      else n_pass++;
      bus_gnt = 1; tick(); bus_gnt = 0;
      mem_valid = 1; mem_rdata = 8'h77; bus_shared_in = 1;
      tick(); mem_valid = 0; bus_shared_in = 0;
      n_total++; if (cpu_ready !== 1'b1 || cpu_rdata !== 8'h77)
         $display("FAIL wb_fill got=%0h/%0h exp=1/77", cpu_ready, cpu_rdata); else n_pass++;
      cpu_req = 0; tick();
      snp_valid = 1; snp_cmd = 2'd1; snp_addr = 5'h0D;
      tick();
      n_total++; if (snp_shared !== 1'b1 || snp_flush !== 1'b0)
         $display("FAIL snprd_s got=%0h/%0h exp=1/0", snp_shared, snp_flush); else n_pass++;
      snp_cmd = 2'd2; snp_addr = 5'h0A;
      tick(); snp_valid = 0;
      n_total++; if ({snp_shared, snp_flush, snp_data} !== 10'h0)
         $display("FAIL snp_miss got=%0h exp=0", {snp_shared, snp_flush, snp_data}); else n_pass++;
   endtask

   task automatic test_upgr_snoop_inval();
      cpu_req = 1; cpu_we = 1; cpu_addr = 5'h0D; cpu_wdata = 8'h99;
      tick();
      n_total++; if (bus_cmd !== 2'd3) $display("FAIL inv_upgr_cmd got=%0h exp=3", bus_cmd); else n_pass++;
      snp_valid = 1; snp_cmd = 2'd2; snp_addr = 5'h0D;
      tick(); snp_valid = 0;
      n_total++; if (bus_req !== 1'b1 || bus_cmd !== 2'd2 || bus_addr !== 5'h0D)
         $display("FAIL inv_rdx got=%0h/%0h/%0h exp=1/2/0d", bus_req, bus_cmd, bus_addr); else n_pass++;
      n_total++; if (snp_flush !== 1'b0 || snp_shared !== 1'b0)
         $display("FAIL inv_snp_resp got=%0h/%0h exp=0/0", snp_flush, snp_shared); else n_pass++;
      bus_gnt = 1; tick(); bus_gnt = 0;
      mem_valid = 1; mem_rdata = 8'h11;
      tick(); mem_valid = 0;
      n_total++; if (cpu_ready !== 1'b1) $display("FAIL inv_ready got=%0h exp=1", cpu_ready); else n_pass++;
      cpu_req = 0; cpu_we = 0; tick();
      snp_valid = 1; snp_cmd = 2'd1; snp_addr = 5'h0D;
      tick(); snp_valid = 0;
      n_total++; if (snp_flush !== 1'b1 || snp_data !== 8'h99)
         $display("FAIL inv_final_m got=%0h/%0h exp=1/99", snp_flush, snp_data); else n_pass++;
   endtask

   task automatic test_reset_mid_fill();
      cpu_req = 1; cpu_we = 0; cpu_addr = 5'h1F;
      tick();
      n_total++; if (bus_req !== 1'b1) $display("FAIL mid_miss_req got=%0h exp=1", bus_req); else n_pass++;
      bus_gnt = 1; tick(); bus_gnt = 0;
      reset_n = 0; mem_valid = 1; mem_rdata = 8'hEE;
      tick();
      n_total++; if (bus_req !== 1'b0 || cpu_ready !== 1'b0)
         $display("FAIL mid_rst_outs got=%0h/%0h exp=0/0", bus_req, cpu_ready); else n_pass++;
      reset_n = 1; mem_valid = 0; cpu_req = 0;
      tick();
      cpu_req = 1; cpu_addr = 5'h0D;
      tick();
      n_total++; if (bus_req !== 1'b1 || bus_cmd !== 2'd1)
         $display("FAIL post_rst_miss got=%0h/%0h exp=1/1", bus_req, bus_cmd); else n_pass++;
      bus_gnt = 1; tick(); bus_gnt = 0;
      mem_valid = 1; mem_rdata = 8'h21;
      tick(); mem_valid = 0;
      n_total++; if (cpu_rdata !== 8'h21) $display("FAIL post_rst_rdata got=%0h exp=21", cpu_rdata); else n_pass++;
      cpu_req = 0; tick();
      cpu_req = 1; cpu_addr = 5'h1F;
      tick();
      n_total++; if (bus_req !== 1'b1) $display("FAIL no_partial_fill got=%0h exp=1", bus_req); else n_pass++;
      bus_gnt = 1; tick(); bus_gnt = 0;
      mem_valid = 1; mem_rdata = 8'h3C;
      tick(); mem_valid = 0;
      n_total++; if (cpu_rdata !== 8'h3C) $display("FAIL refill_rdata got=%0h exp=3c", cpu_rdata); else n_pass++;
      cpu_req = 0; tick();
   endtask

   task automatic test_same_cycle_snoop();
      // 0x0D holds E; a coincident foreign read demotes it to S, so the write must upgrade.
      cpu_req = 1; cpu_we = 1; cpu_addr = 5'h0D; cpu_wdata = 8'h55;
      snp_valid = 1; snp_cmd = 2'd1; snp_addr = 5'h0D;
      tick(); snp_valid = 0;
      n_total++; if (bus_req !== 1'b1 || bus_cmd !== 2'd3)
         $display("FAIL same_cyc_upgr got=%0h/%0h exp=1/3", bus_req, bus_cmd); else n_pass++;
      n_total++; if (snp_shared !== 1'b1 || snp_flush !== 1'b0)
         $display("FAIL same_cyc_snp got=%0h/%0h exp=1/0", snp_shared, snp_flush); else n_pass++;
      bus_gnt = 1; tick(); bus_gnt = 0;
      n_total++; if (cpu_ready !== 1'b1) $display("FAIL same_cyc_ready got=%0h exp=1", cpu_ready); else n_pass++;
      cpu_req = 0; cpu_we = 0; tick();
      snp_valid = 1; snp_cmd = 2'd1; snp_addr = 5'h0D;
      tick(); snp_valid = 0;
      n_total++; if (snp_flush !== 1'b1 || snp_data !== 8'h55)
         $display("FAIL same_cyc_final got=%0h/%0h exp=1/55", snp_flush, snp_data); else n_pass++;
      tick();
   endtask

   initial begin
      test_reset();
      test_read_miss();
      test_write_hit_e();
      test_upgrade();
      test_writeback();
      test_upgr_snoop_inval();
      test_reset_mid_fill();
      test_same_cycle_snoop();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
